// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide engine for the EX stage.
// Multiplies by shift-add and divides by restoring division, one bit per cycle,
// on operand magnitudes. The result's sign is fixed on the final edge.
//
// Handshake: an M instruction is offered by holding startE high in EX. It is
// accepted on the rising edge where the FSM is in IDLE, startE=1 and flushE=0.
// stallMD holds the pipeline from that acceptance cycle until the last
// iteration. doneMD then pulses for one cycle, with resultMD valid and stallMD
// low, so the instruction advances on that edge. flushE abandons a running
// operation without a doneMD pulse.
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  startE,
    input  logic [2:0]            funct3E,
    input  logic [DATA_WIDTH-1:0] srcAE,
    input  logic [DATA_WIDTH-1:0] srcBE,
    input  logic                  flushE,
    output logic                  stallMD,
    output logic                  doneMD,
    output logic [DATA_WIDTH-1:0] resultMD,
    output logic [1:0]            dbg_state
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state;
    logic [4:0]     count;
    logic [2:0]     op;
    logic [W-1:0]   b_mag;
    logic           neg_res;   // product / quotient must be negated
    logic           neg_rem;   // remainder takes the sign of A
    // MUL: {acc_hi, acc_lo} is the product accumulator (acc_hi[W] stays 0).
    // DIV: acc_hi is the remainder R, acc_lo is the quotient register Q.
    logic [W:0]     acc_hi;
    logic [W-1:0]   acc_lo;

    // Operand decode at acceptance time
    logic           a_signed;
    logic           b_signed;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag_in;
    logic [W-1:0]   b_mag_in;
    logic           div_zero;
    logic           div_ovf;
    logic [W-1:0]   special_res;

    // Per-iteration datapath
    logic [W:0]     mul_sum;
    logic [W:0]     mul_hi_next;
    logic [W-1:0]   mul_lo_next;
    logic [W:0]     r_sh;
    logic [W:0]     r_next;
    logic [W-1:0]   q_next;

    // Result selection on the final iteration
    logic [2*W-1:0] product;
    logic [2*W-1:0] product_fix;
    logic [W-1:0]   quot_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   final_res;

    // Signedness, magnitudes and the no-iteration divide cases for the offered op
    always_comb begin
        a_signed    = (funct3E == 3'b001) || (funct3E == 3'b010) ||
                      (funct3E == 3'b100) || (funct3E == 3'b110);
        b_signed    = (funct3E == 3'b001) || (funct3E == 3'b100) ||
                      (funct3E == 3'b110);
        a_neg       = a_signed && srcAE[W-1];
        b_neg       = b_signed && srcBE[W-1];
        a_mag_in    = a_neg ? (~srcAE + 1'b1) : srcAE;
        b_mag_in    = b_neg ? (~srcBE + 1'b1) : srcBE;
        div_zero    = funct3E[2] && (srcBE == '0);
        div_ovf     = funct3E[2] && !funct3E[0] &&
                      (srcAE == {1'b1, {(W-1){1'b0}}}) && (srcBE == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = funct3E[1] ? srcAE : '1;
        end else if (div_ovf) begin
            special_res = funct3E[1] ? '0 : {1'b1, {(W-1){1'b0}}};
        end
    end

    // One shift-add step and one restoring-divide step from the current registers
    always_comb begin
        mul_sum     = acc_hi + (acc_lo[0] ? {1'b0, b_mag} : '0);
        mul_hi_next = {1'b0, mul_sum[W:1]};
        mul_lo_next = {mul_sum[0], acc_lo[W-1:1]};
        r_sh        = {acc_hi[W-1:0], acc_lo[W-1]};
        q_next      = {acc_lo[W-2:0], 1'b0};
        r_next      = r_sh;
        if (r_sh >= {1'b0, b_mag}) begin
            r_next    = r_sh - {1'b0, b_mag};
            q_next[0] = 1'b1;
        end
    end

    // Sign-fixed result as it will stand after the last iteration
    always_comb begin
        product     = {mul_hi_next[W-1:0], mul_lo_next};
        product_fix = neg_res ? (~product + 1'b1) : product;
        quot_fix    = neg_res ? (~q_next + 1'b1) : q_next;
        rem_fix     = neg_rem ? (~r_next[W-1:0] + 1'b1) : r_next[W-1:0];
        if (op[2]) begin
            final_res = op[1] ? rem_fix : quot_fix;
        end else begin
            final_res = (op[1:0] == 2'b00) ? product_fix[W-1:0] : product_fix[2*W-1:W];
        end
    end

    // Sequencing FSM with its datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            op       <= '0;
            b_mag    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            doneMD   <= 1'b0;
            resultMD <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    doneMD <= 1'b0;
                    if (startE && !flushE) begin
                        op      <= funct3E;
                        b_mag   <= b_mag_in;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        count   <= '0;
                        acc_hi  <= '0;
                        acc_lo  <= a_mag_in;
                        if (!funct3E[2]) begin
                            state <= S_MUL;
                        end else if (div_zero || div_ovf) begin
                            resultMD <= special_res;
                            doneMD   <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (flushE) begin
                        state <= S_IDLE;
                    end else begin
                        if (state == S_MUL) begin
                            acc_hi <= mul_hi_next;
                            acc_lo <= mul_lo_next;
                        end else begin
                            acc_hi <= r_next;
                            acc_lo <= q_next;
                        end
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            resultMD <= final_res;
                            doneMD   <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    doneMD <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    doneMD <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign stallMD   = ((state == S_IDLE) && startE && !flushE) ||
                       (state == S_MUL) || (state == S_DIV);
    assign dbg_state = state;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide engine and its sequencing FSM, in the EX stage beside the main ALU. The ID-stage decoder flags M-extension instructions (opcode 0110011, funct7 0000001). This block accepts the flagged instruction's operands and runs a 32-iteration shift-add or restoring-divide sequence. While it runs it asserts a stall to the hazard logic, then presents a one-cycle result for the EX/MEM register.

## Interface
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- startE  in  1  valid M-extension instruction in EX; sampled only in IDLE.
- funct3E  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srcAE  in  DATA_WIDTH  rs1 operand, post-forwarding.
- srcBE  in  DATA_WIDTH  rs2 operand, post-forwarding.
- flushE  in  1  kill the EX instruction; aborts any operation in progress.
- stallMD  out  1  freeze PC/IF/ID/EX; combinational.
- doneMD  out  1  resultMD valid this cycle; registered.
- resultMD  out  DATA_WIDTH  final result; held until the next accepted start.

## Operation
- States are IDLE, MUL, DIV and DONE. Reset puts the FSM in IDLE with count=0, doneMD=0, resultMD=0 and all internal registers cleared.
- Leaving IDLE (startE=1, flushE=0):
  - The block latches funct3, the operand magnitudes and the result-sign flags.
  - Signedness by op: MULH and DIV/REM treat both operands as signed. MULHSU treats A as signed and B as unsigned. MUL, MULHU, DIVU and REMU are unsigned.
  - funct3[2]=0 goes to MUL. funct3[2]=1 goes to DIV, except for the special cases below.
- Special cases go IDLE→DONE directly, with no iterations:
  - Divide by zero (B==0): quotient 0xFFFFFFFF; remainder is the original A.
  - Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): quotient 0x80000000, remainder 0.
- MUL state:
  - 64-bit accumulator {hi,lo}, lo initialised to |A|.
  - Each cycle: if lo[0], hi += |B| (33-bit carry); then shift the 65-bit {carry,hi,lo} right by 1.
  - 32 iterations.
- DIV state:
  - Restoring division. 33-bit remainder R=0, quotient register Q=|A|.
  - Each cycle: {R,Q} <<= 1; trial = R − |B|. If trial ≥ 0, R=trial and Q[0]=1.
  - 32 iterations.
- count is 5 bits and increments every iteration cycle. On the cycle count==31 the FSM moves to DONE.
- On the same edge as that move, resultMD is loaded with the sign-fixed selection:
  - MUL: low word. MULH/MULHSU/MULHU: high word.
  - 64-bit product negated when sign(A)^sign(B) and the op is signed.
  - Quotient negated when sign(A)^sign(B). Remainder takes the sign of A.
- DONE: doneMD=1 for exactly one cycle, then the FSM returns to IDLE unconditionally. startE is ignored in DONE, because the EX instruction is the one just completed.
- flushE=1 in MUL or DIV returns the FSM to IDLE next cycle: no doneMD, resultMD unchanged. flushE=1 in IDLE blocks a start. flushE in DONE is ignored; the hazard logic discards the result.
- stallMD = (IDLE & startE & ~flushE) | MUL | DIV. It is 0 in DONE, so the pipeline advances on the DONE edge.

## Timing
- Cycle 0: IDLE with startE → stallMD=1 and operands latched.
- Cycles 1–32: MUL/DIV with stallMD=1, count 0..31.
- Cycle 33: DONE with doneMD=1, resultMD valid and stallMD=0.
- Total latency is 33 cycles from start to doneMD, with 33 stall cycles.
- Special cases: cycle 0 stall, cycle 1 DONE; latency 1.
- Back-to-back M instructions: the second reaches EX in the cycle after DONE (IDLE) and starts immediately, with no bubble.
- rst asserted in any state → IDLE next edge, with all outputs 0 in the following cycle; it overrides flushE and startE.
- All arithmetic is unsigned on magnitudes. Negation is two's complement at DATA_WIDTH (or 64 bits for the product) and truncates.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3): stallMD high cycles 0–32; doneMD at cycle 33 with resultMD=0xFFFFFFEB; stallMD=0 on that cycle.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. Each completes at cycle 33.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, with doneMD at cycle 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, also at cycle 1.
- Start DIV, assert flushE at cycle 10: IDLE at cycle 11, stallMD=0, doneMD never asserts, resultMD unchanged. A new MUL 3×4 started at cycle 12 returns 12 at cycle 45.
- Assert rst at cycle 20 of a MUL: IDLE next cycle with doneMD=0, resultMD=0 and stallMD=0. Also check two back-to-back MULs complete at cycles 33 and 67.
